uart_prog_loader: RTL and testbench

- Parametrised successor to the serial program loader that fills core program memory while the CPU is held in reset.
- Receives framed UART 8N1 data and assembles little-endian words of DATA_W bits.
- Issues one-cycle program-memory write strobes, verifies a frame checksum, and answers each frame with an ACK or NAK byte on its own TX line.
- Sits beside the core on the undivided board clock. The enable input is driven from the CPU run/reset state.

---
 rtl/uart_prog_pkg.sv | 14 +
 rtl/uart_rx_byte.sv | 90 +++++++++
 rtl/uart_prog_loader.sv | 206 ++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_prog_pkg.sv
// Shared constants and state encodings for the UART program loader.
package uart_prog_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'h55;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDRH, S_ADDRL, S_COUNT, S_DATA, S_CHECK, S_RESP
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver on an already-synchronised line; held idle while arm is low.
module uart_rx_byte
  import uart_prog_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_sync,
  input  logic       arm,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    sh, sh_n;
  logic          rx_prev, valid_n, ferr_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      sh        <= '0;
      rx_prev   <= 1'b1;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      sh        <= sh_n;
      rx_prev   <= rx_sync;
      valid     <= valid_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    st_n    = st;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = sh;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (st)
      RX_IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        if (rx_prev && !rx_sync) st_n = RX_START;
      end
      RX_START: begin
        // a line that is high again at mid-start was only a glitch
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          st_n  = rx_sync ? RX_IDLE : RX_DATA;
        end else cnt_n = cnt + CW'(1);
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          sh_n  = {rx_sync, sh[7:1]};
          if (bit_idx == 3'd7) st_n = RX_STOP;
          else bit_n = bit_idx + 3'd1;
        end else cnt_n = cnt + CW'(1);
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          st_n    = RX_IDLE;
          valid_n = rx_sync;
          ferr_n  = !rx_sync;
        end else cnt_n = cnt + CW'(1);
      end
      default: st_n = RX_IDLE;
    endcase
    if (!arm) begin
      st_n    = RX_IDLE;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
    end
  end

  assign data = sh;
endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: receives framed words over UART, strobes them into
// program memory and answers each frame with ACK/NAK on tx.
module uart_prog_loader
  import uart_prog_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 16,
  parameter int TIMEOUT_CLKS = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rx,
  output logic              tx,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_data,
  output logic              prog_we,
  output logic              busy,
  output logic              err
);
  localparam int BYTES = DATA_W / 8;
  localparam int TW    = $clog2(TIMEOUT_CLKS + 1);
  localparam int TXW   = $clog2(CLKS_PER_BIT);
  localparam logic [1:0]     LAST_BYTE = 2'(BYTES - 1);
  localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [TXW-1:0] TX_LAST   = TXW'(CLKS_PER_BIT - 1);

  logic       rx_meta, rx_sync;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  ld_state_e         state, state_n;
  logic [7:0]        addr_h, addr_h_n, sum, sum_n, sum_next;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] asm_q, asm_n, asm_word, data_q, data_n;
  logic              we_q, we_n, err_q, err_n, tx_q, tx_q_n;
  logic [1:0]        byte_idx, byte_idx_n;
  logic [8:0]        word_cnt, word_cnt_n;
  logic [9:0]        tx_sh, tx_sh_n;
  logic [TXW-1:0]    tx_cnt, tx_cnt_n;
  logic [3:0]        tx_bits, tx_bits_n;
  logic [TW-1:0]     to_cnt, to_cnt_n;
  logic [15:0]       full_addr;

  // the receiver is deaf while the response is on the wire
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx_sync  (rx_sync),
    .arm      (en && (state != S_RESP)),
    .data     (rx_data),
    .valid    (rx_valid),
    .frame_err(rx_ferr)
  );

  assign sum_next  = sum + rx_data;
  assign full_addr = {addr_h, rx_data};

  // little-endian word assembly: byte k lands in bits [8k+7:8k]
  always_comb begin
    asm_word = asm_q;
    for (int i = 0; i < BYTES; i++)
      if (byte_idx == 2'(i)) asm_word[i*8 +: 8] = rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      addr_h   <= '0;
      addr_q   <= '0;
      asm_q    <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      byte_idx <= '0;
      word_cnt <= '0;
      sum      <= '0;
      tx_sh    <= '1;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_q     <= 1'b1;
      to_cnt   <= '0;
    end else begin
      state    <= state_n;
      addr_h   <= addr_h_n;
      addr_q   <= addr_n;
      asm_q    <= asm_n;
      data_q   <= data_n;
      we_q     <= we_n;
      err_q    <= err_n;
      byte_idx <= byte_idx_n;
      word_cnt <= word_cnt_n;
      sum      <= sum_n;
      tx_sh    <= tx_sh_n;
      tx_cnt   <= tx_cnt_n;
      tx_bits  <= tx_bits_n;
      tx_q     <= tx_q_n;
      to_cnt   <= to_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    addr_h_n   = addr_h;
    addr_n     = we_q ? addr_q + ADDR_W'(1) : addr_q;
    asm_n      = asm_q;
    data_n     = data_q;
    we_n       = 1'b0;
    err_n      = err_q;
    byte_idx_n = byte_idx;
    word_cnt_n = word_cnt;
    sum_n      = sum;
    tx_sh_n    = tx_sh;
    tx_cnt_n   = tx_cnt;
    tx_bits_n  = tx_bits;
    to_cnt_n   = (state == S_IDLE || state == S_RESP || rx_valid) ? '0 : to_cnt + TW'(1);
    case (state)
      S_IDLE:
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_n = S_ADDRH;
          err_n   = 1'b0;
        end
      S_ADDRH:
        if (rx_valid) begin
          addr_h_n = rx_data;
          sum_n    = rx_data;
          state_n  = S_ADDRL;
        end
      S_ADDRL:
        if (rx_valid) begin
          addr_n  = full_addr[ADDR_W-1:0];
          sum_n   = sum_next;
          state_n = S_COUNT;
        end
      S_COUNT:
        if (rx_valid) begin
          word_cnt_n = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          byte_idx_n = '0;
          sum_n      = sum_next;
          state_n    = S_DATA;
        end
      S_DATA:
        if (rx_valid) begin
          sum_n = sum_next;
          asm_n = asm_word;
          if (byte_idx == LAST_BYTE) begin
            byte_idx_n = '0;
            data_n     = asm_word;
            we_n       = 1'b1;
            word_cnt_n = word_cnt - 9'd1;
            if (word_cnt == 9'd1) state_n = S_CHECK;
          end else byte_idx_n = byte_idx + 2'd1;
        end
      S_CHECK:
        if (rx_valid) begin
          state_n   = S_RESP;
          tx_sh_n   = {1'b1, (sum_next == 8'd0) ? ACK_BYTE : NAK_BYTE, 1'b0};
          tx_cnt_n  = '0;
          tx_bits_n = '0;
          if (sum_next != 8'd0) err_n = 1'b1;
        end
      S_RESP:
        if (tx_cnt == TX_LAST) begin
          tx_cnt_n = '0;
          tx_sh_n  = {1'b1, tx_sh[9:1]};
          if (tx_bits == 4'd9) state_n = S_IDLE;
          else tx_bits_n = tx_bits + 4'd1;
        end else tx_cnt_n = tx_cnt + TXW'(1);
      default: state_n = S_IDLE;
    endcase
    if (rx_ferr) begin
      state_n = S_IDLE;
      err_n   = 1'b1;
      we_n    = 1'b0;
    end
    if (to_cnt == TO_LAST && !rx_valid && state != S_IDLE && state != S_RESP) begin
      state_n = S_IDLE;
      err_n   = 1'b1;
      we_n    = 1'b0;
    end
    if (!en) begin
      state_n = S_IDLE;
      we_n    = 1'b0;
    end
    tx_q_n = (state_n == S_RESP) ? tx_sh_n[0] : 1'b1;
  end

  // en gates the outputs directly so a drop takes effect in the same cycle
  assign tx        = tx_q | ~en;
  assign prog_we   = we_q & en;
  assign busy      = (state != S_IDLE) & en;
  assign err       = err_q;
  assign prog_addr = addr_q;
  assign prog_data = data_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench: two loader instances (16-bit and 32-bit words) driven by
// directed and random frames; monitors compare writes and response bytes.
module tb_uart_prog_loader;
  localparam int CPB = 8;
  localparam int TO  = 500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  rx_d, en_d;
  logic        tx0, we0, busy0, err0, tx1, we1, busy1, err1;
  logic [15:0] addr0, data0;
  logic [11:0] addr1;
  logic [31:0] data1;

  logic [1:0]       tx_w, we_w, busy_w, err_w;
  logic [1:0][15:0] addr_w;
  logic [1:0][31:0] data_w;

  assign tx_w   = {tx1, tx0};
  assign we_w   = {we1, we0};
  assign busy_w = {busy1, busy0};
  assign err_w  = {err1, err0};
  assign addr_w[0] = addr0;
  assign addr_w[1] = {4'h0, addr1};
  assign data_w[0] = {16'h0, data0};
  assign data_w[1] = data1;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .DATA_W(16), .ADDR_W(16), .TIMEOUT_CLKS(TO)) dut0 (
    .clk(clk), .rst(rst_n), .en(en_d[0]), .rx(rx_d[0]), .tx(tx0),
    .prog_addr(addr0), .prog_data(data0), .prog_we(we0), .busy(busy0), .err(err0));

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .DATA_W(32), .ADDR_W(12), .TIMEOUT_CLKS(TO)) dut1 (
    .clk(clk), .rst(rst_n), .en(en_d[1]), .rx(rx_d[1]), .tx(tx1),
    .prog_addr(addr1), .prog_data(data1), .prog_we(we1), .busy(busy1), .err(err1));

  int checks = 0;
  int errors = 0;

  logic [47:0] wq [2][$];
  logic [7:0]  rq [2][$];
  logic [7:0]  fbuf [$];
  logic [31:0] wbuf [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_mon
    always @(negedge clk) begin
      if (we_w[g] === 1'b1) begin
        if (wq[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL write_unexpected dut%0d actual=%0h/%0h required=none", g, addr_w[g], data_w[g]);
        end else
          check($sformatf("write_dut%0d", g), {16'h0, addr_w[g], data_w[g]}, {16'h0, wq[g].pop_front()});
      end
    end

    initial begin : txmon
      logic [7:0] b;
      logic       stp;
      forever begin
        @(negedge clk);
        if (tx_w[g] === 1'b0) begin
          repeat (CPB / 2) @(negedge clk);
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx_w[g];
          end
          repeat (CPB) @(negedge clk);
          stp = tx_w[g];
          if (rq[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected dut%0d actual=%0h required=none", g, b);
          end else
            check($sformatf("resp_dut%0d", g), {55'h0, stp, b}, {55'h0, 1'b1, rq[g].pop_front()});
        end
      end
    end
  end

  // Reference model: frame bytes, expected writes and the reply follow
  // directly from the frame rules (address wrap, checksum over ADDR_H..CHK).
  task automatic build_frame(input int idx, input logic [15:0] addr, input logic [7:0] cnt,
                             input int nexp, input bit bad, input bit resp);
    int nw = (cnt == 8'd0) ? 256 : int'(cnt);
    int nb = (idx == 0) ? 2 : 4;
    int aw = (idx == 0) ? 16 : 12;
    logic [7:0]  s;
    logic [31:0] w;
    logic [15:0] a;
    fbuf.delete();
    fbuf.push_back(8'h55);
    fbuf.push_back(addr[15:8]);
    fbuf.push_back(addr[7:0]);
    fbuf.push_back(cnt);
    for (int i = 0; i < nw; i++) begin
      w = wbuf[i];
      if (nb == 2) w[31:16] = 16'h0;
      for (int k = 0; k < nb; k++) fbuf.push_back(8'(w >> (8 * k)));
      a = 16'((32'(addr) + 32'(i)) % (32'd1 << aw));
      if (i < nexp) wq[idx].push_back({a, w});
    end
    s = 8'h00;
    for (int i = 1; i < fbuf.size(); i++) s = s + fbuf[i];
    s = 8'h00 - s + (bad ? 8'h01 : 8'h00);
    fbuf.push_back(s);
    if (resp) rq[idx].push_back(bad ? 8'h15 : 8'h06);
  endtask

  task automatic fill_words(input int n);
    wbuf.delete();
    for (int i = 0; i < n; i++) wbuf.push_back($urandom);
  endtask

  task automatic send_byte(input int idx, input logic [7:0] b, input logic stop_bit);
    @(negedge clk) rx_d[idx] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      rx_d[idx] = b[i];
    end
    repeat (CPB) @(negedge clk);
    rx_d[idx] = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_d[idx] = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_range(input int idx, input int lo, input int hi);
    for (int i = lo; i < hi; i++) send_byte(idx, fbuf[i], 1'b1);
  endtask

  task automatic wait_idle(input int idx);
    int n = 0;
    while (busy_w[idx] !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (busy_w[idx] !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_wait dut%0d actual=busy required=idle", idx);
    end
  endtask

  task automatic run_frame(input int idx, input logic [15:0] addr, input logic [7:0] cnt, input bit bad);
    build_frame(idx, addr, cnt, (cnt == 8'd0) ? 256 : int'(cnt), bad, 1'b1);
    send_range(idx, 0, fbuf.size());
    wait_idle(idx);
    repeat (2) @(negedge clk);
    check($sformatf("err_after_frame_dut%0d", idx), {63'h0, err_w[idx]}, {63'h0, bad});
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin : stim
    rst_n = 1'b0;
    rx_d  = 2'b11;
    en_d  = 2'b11;
    repeat (3) @(negedge clk);
    check("rst_tx",   {63'h0, tx0},   64'h1);
    check("rst_we",   {63'h0, we0},   64'h0);
    check("rst_addr", {48'h0, addr0}, 64'h0);
    check("rst_data", {48'h0, data0}, 64'h0);
    check("rst_busy", {63'h0, busy0}, 64'h0);
    check("rst_err",  {63'h0, err0},  64'h0);
    check("rst_busy1", {63'h0, busy1}, 64'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // basic two-word frame, then the same frame with a bad checksum
    wbuf.delete();
    wbuf.push_back(32'h1234);
    wbuf.push_back(32'h5678);
    run_frame(0, 16'h0100, 8'd2, 1'b0);
    run_frame(0, 16'h0100, 8'd2, 1'b1);

    // the next SYNC alone clears the sticky error
    build_frame(0, 16'h0100, 8'd2, 2, 1'b0, 1'b1);
    send_range(0, 0, 1);
    check("sync_clears_err", {63'h0, err0}, 64'h0);
    check("busy_after_sync", {63'h0, busy0}, 64'h1);
    send_range(0, 1, fbuf.size());
    wait_idle(0);

    // address wrap at the top of the space
    fill_words(2);
    run_frame(0, 16'hFFFF, 8'd2, 1'b0);

    // framing error on ADDR_L: no writes, no reply
    send_byte(0, 8'h55, 1'b1);
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h00, 1'b0);
    repeat (4) @(negedge clk);
    check("ferr_err",  {63'h0, err0},  64'h1);
    check("ferr_busy", {63'h0, busy0}, 64'h0);
    fill_words(3);
    run_frame(0, 16'h2000, 8'd3, 1'b0);

    // inter-byte timeout
    send_byte(0, 8'h55, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h10, 1'b1);
    repeat (450) @(negedge clk);
    check("to_busy_before", {63'h0, busy0}, 64'h1);
    repeat (100) @(negedge clk);
    check("to_busy_after", {63'h0, busy0}, 64'h0);
    check("to_err",        {63'h0, err0},  64'h1);

    // random back-to-back frames
    for (int f = 0; f < 6; f++) begin
      fill_words(4);
      run_frame(0, 16'($urandom), 8'($urandom_range(1, 3)), ($urandom_range(0, 2) == 0));
    end

    // 32-bit instance: 256-word frame abandoned by dropping en after word 10
    fill_words(256);
    build_frame(1, 16'hABC0, 8'd0, 10, 1'b0, 1'b0);
    send_range(1, 0, 4 + 10 * 4);
    check("drop_busy_before", {63'h0, busy1}, 64'h1);
    en_d[1] = 1'b0;
    #1;
    check("drop_busy_same_cycle", {63'h0, busy1}, 64'h0);
    check("drop_tx_high",         {63'h0, tx1},   64'h1);
    for (int i = 44; i < 48; i++) send_byte(1, fbuf[i], 1'b1);
    check("drop_writes_done", 64'(wq[1].size()), 64'h0);
    check("drop_tx_still_high", {63'h0, tx1}, 64'h1);
    en_d[1] = 1'b1;
    repeat (4) @(negedge clk);
    check("reenable_idle", {63'h0, busy1}, 64'h0);
    fill_words(2);
    run_frame(1, 16'h1FFF, 8'd2, 1'b0);

    repeat (20) @(negedge clk);
    check("wq0_drained", 64'(wq[0].size()), 64'h0);
    check("wq1_drained", 64'(wq[1].size()), 64'h0);
    check("rq0_drained", 64'(rq[0].size()), 64'h0);
    check("rq1_drained", 64'(rq[1].size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
